// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous dmem, with read-tag return pipeline.
// Build option DMEM_ARB_RR_EN: round-robin priority instead of fixed priority with starvation guard.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_WAIT     = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LAST_S = READ_LATENCY - 1;

    logic                    sel1;
    logic [READ_LATENCY-1:0] tag_vld;
    logic [READ_LATENCY-1:0] tag_port;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    // On contention the port that did not win last time is served.
    always_comb begin
        sel1 = req1;
        if (req0 && req1) begin
            sel1 = (last_grant == 1'b0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] wait_cnt;
    logic             force1;

    // Port 0 wins unless port 1 has waited MAX_WAIT consecutive cycles.
    always_comb begin
        force1 = req1 && (wait_cnt == CNT_W'(MAX_WAIT));
        sel1   = req1 && (!req0 || force1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!req1 || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

    // Grants and the dmem drive are combinational so the access lands in the grant cycle.
    always_comb begin
        gnt0        = !reset && req0 && !sel1;
        gnt1        = !reset && sel1;
        mem_address = addr0;
        mem_data    = wdata0;
        mem_wren    = gnt0 && we0;
        if (gnt1) begin
            mem_address = addr1;
            mem_data    = wdata1;
            mem_wren    = we1;
        end
    end

    // Read tags travel alongside the dmem read latency; stage 0 is the grant edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld[0]  <= (gnt0 && !we0) || (gnt1 && !we1);
            tag_port[0] <= gnt1;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
        end
    end

    assign rvalid0 = tag_vld[LAST_S] && !tag_port[LAST_S];
    assign rvalid1 = tag_vld[LAST_S] && tag_port[LAST_S];
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural two-cycle-latency dmem.
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;
    localparam int unsigned MW = 4;

    logic          clock;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    int n_checks;
    int n_errors;

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_WAIT(MW)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port memory, RL cycles from address to q.
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] q_pipe [0:RL-1];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        q_pipe[0] <= mem[mem_address];
        for (int i = 1; i < int'(RL); i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_ports(input logic r0, input logic w0, input logic [AW-1:0] a0,
                             input logic [DW-1:0] d0, input logic r1, input logic w1,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    // Both ports request continuously: port 0 stores, port 1 loads 0x021 (holds 0x22).
    task automatic run_contention(input int n);
        logic [RL-1:0] hist;
        logic          exp_g1;
        logic          exp_rv1;
        hist = '0;
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g1 = (i % 2) == 1;
`else
            exp_g1 = (i % (MW + 1)) == MW;
`endif
            exp_rv1 = hist[RL-1];
            #1;
            check($sformatf("cont%0d_gnt0", i), 32'(gnt0), 32'(!exp_g1));
            check($sformatf("cont%0d_gnt1", i), 32'(gnt1), 32'(exp_g1));
            check($sformatf("cont%0d_wren", i), 32'(mem_wren), 32'(!exp_g1));
            check($sformatf("cont%0d_rv0", i), 32'(rvalid0), 32'd0);
            check($sformatf("cont%0d_rv1", i), 32'(rvalid1), 32'(exp_rv1));
            if (exp_rv1) check($sformatf("cont%0d_rdata1", i), rdata1, 32'h22);
            hist = {hist[RL-2:0], exp_g1};
            @(negedge clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        set_ports(1'b1, 1'b1, 12'h005, 32'h1, 1'b1, 1'b0, 12'h006, 32'h0);

        // Reset: grants and write enable forced low even with requests present.
        repeat (2) @(negedge clock);
        #1;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_rv0", 32'(rvalid0), 32'd0);
        check("rst_rv1", 32'(rvalid1), 32'd0);
        @(negedge clock);
        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        reset = 1'b0;

        // Port 0 alone: store then load.
        @(negedge clock);
        set_ports(1'b1, 1'b1, 12'h010, 32'hAB, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        check("p0w_gnt0", 32'(gnt0), 32'd1);
        check("p0w_gnt1", 32'(gnt1), 32'd0);
        check("p0w_wren", 32'(mem_wren), 32'd1);
        check("p0w_addr", 32'(mem_address), 32'h010);
        check("p0w_data", mem_data, 32'hAB);
        @(negedge clock);
        set_ports(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        check("p0r_gnt0", 32'(gnt0), 32'd1);
        check("p0r_wren", 32'(mem_wren), 32'd0);
        @(negedge clock);
        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        check("p0r_rv0_early", 32'(rvalid0), 32'd0);
        @(negedge clock);
        #1;
        check("p0r_rv0", 32'(rvalid0), 32'd1);
        check("p0r_rdata0", rdata0, 32'hAB);
        check("p0r_rv1", 32'(rvalid1), 32'd0);
        @(negedge clock);
        #1;
        check("p0r_rv0_done", 32'(rvalid0), 32'd0);

        // Preload 0x020/0x021, then alternating-port reads back to back.
        @(negedge clock);
        set_ports(1'b1, 1'b1, 12'h020, 32'h11, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        check("pre0_gnt0", 32'(gnt0), 32'd1);
        @(negedge clock);
        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h021, 32'h22);
        #1;
        check("pre1_gnt1", 32'(gnt1), 32'd1);
        check("pre1_wren", 32'(mem_wren), 32'd1);
        check("pre1_addr", 32'(mem_address), 32'h021);
        check("pre1_data", mem_data, 32'h22);
        @(negedge clock);
        set_ports(1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        check("alt0_gnt0", 32'(gnt0), 32'd1);
        @(negedge clock);
        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h021, 32'h0);
        #1;
        check("alt1_gnt1", 32'(gnt1), 32'd1);
        check("alt1_gnt0", 32'(gnt0), 32'd0);
        check("alt1_addr", 32'(mem_address), 32'h021);
        @(negedge clock);
        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        #1;
        check("alt_rv0", 32'(rvalid0), 32'd1);
        check("alt_rdata0", rdata0, 32'h11);
        check("alt_rv1_early", 32'(rvalid1), 32'd0);
        @(negedge clock);
        #1;
        check("alt_rv1", 32'(rvalid1), 32'd1);
        check("alt_rdata1", rdata1, 32'h22);
        check("alt_rv0_done", 32'(rvalid0), 32'd0);

        // Continuous contention from an idle start.
        @(negedge clock);
        set_ports(1'b1, 1'b1, 12'h030, 32'h55, 1'b1, 1'b0, 12'h021, 32'h0);
        run_contention(10);
        set_ports(1'b0, 1'b0, 12'h0AB, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        repeat (3) @(negedge clock);

        // Idle: nothing granted, dmem address follows port 0.
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("idle%0d_gnt0", i), 32'(gnt0), 32'd0);
            check($sformatf("idle%0d_gnt1", i), 32'(gnt1), 32'd0);
            check($sformatf("idle%0d_wren", i), 32'(mem_wren), 32'd0);
            check($sformatf("idle%0d_rv0", i), 32'(rvalid0), 32'd0);
            check($sformatf("idle%0d_rv1", i), 32'(rvalid1), 32'd0);
            check($sformatf("idle%0d_addr", i), 32'(mem_address), 32'h0AB);
            @(negedge clock);
        end

        // Port 1 load granted, then reset mid-cycle while its read is in flight.
        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h021, 32'h0);
        #1;
        check("rs_gnt1", 32'(gnt1), 32'd1);
        @(negedge clock);
        set_ports(1'b1, 1'b1, 12'h030, 32'h55, 1'b1, 1'b0, 12'h021, 32'h0);
        #1;
        check("rs_gnt0", 32'(gnt0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rs_async_gnt0", 32'(gnt0), 32'd0);
        check("rs_async_gnt1", 32'(gnt1), 32'd0);
        check("rs_async_wren", 32'(mem_wren), 32'd0);
        @(negedge clock);
        check("rs_hold_rv1", 32'(rvalid1), 32'd0);
        check("rs_hold_rv0", 32'(rvalid0), 32'd0);
        reset = 1'b0;
        run_contention(10);

        set_ports(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters.
- Port 0 is the processor load/store path; port 1 is a secondary master such as a program loader or debug/DMA engine.
- Per-cycle arbitration: port 0 has fixed priority, with a starvation guard for port 1.
- Read-return tags are pipelined to match dmem read latency, so each read result goes back to the port that issued it.
- Sits between processor/loader and the dmem instance; a drop-in replacement for the direct processor-to-dmem wiring.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, dmem data width.
- READ_LATENCY, 1, cycles from granted read to valid mem_q; legal range 1..4.
- MAX_WAIT, 4, consecutive denied cycles of port 1 before a forced grant; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0  in  1  port 0 (processor) access request.
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 store data.
- gnt0  out  1  port 0 access accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_address  out  ADDR_W  to dmem address.
- mem_data  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem write enable.
- mem_q  in  DATA_W  from dmem q.

Behaviour:
- Clock and reset are fixed: one clock named clock; reset is asynchronous and active-high, named reset.
- Arbitration is combinational within the cycle:
  - At most one of gnt0/gnt1 is high.
  - A gnt is only asserted when the matching req is high.
- Default priority: port 0 wins whenever req0 is high.
- Forced grant to port 1 when req1 is high and wait_cnt == MAX_WAIT, even if req0 is high. Port 0 is then denied for that cycle.
- wait_cnt (4-bit register):
  - +1 each cycle where req1 is high and gnt1 is low; saturates at MAX_WAIT.
  - Cleared on gnt1 or when req1 is low.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high at a posedge.
  - The access is consumed on that edge.
  - It may issue its next request in the following cycle.
- dmem drive:
  - mem_address and mem_data come from the granted port.
  - With no grant they hold port 0 values and mem_wren = 0.
  - mem_wren = granted port's we.
- Read return:
  - Tag pipeline of READ_LATENCY stages; each stage holds {valid, port}.
  - Stage 0 is loaded on posedge with {gnt && !we, granted port}.
  - rvalidN = final stage valid && port == N.
  - rdata0 and rdata1 both carry mem_q; each is qualified only by its own rvalid.
- Writes produce no rvalid. A write and a read-return may coexist in the same cycle (independent pipelines).
- Reads complete in order; with READ_LATENCY > 1, back-to-back reads from alternating ports are legal.
- Reset values:
  - Tag pipeline, rvalid0/1 and wait_cnt are 0.
  - gnt0/1 and mem_wren are forced 0 while reset is high.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them after reset deasserts.
- No requests: gnt0 = gnt1 = 0, mem_wren = 0, pipeline shifts in invalid entries.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Priority is round-robin via a 1-bit last_grant register (reset 1, so port 0 wins first contention).
  - On contention the port not granted last time wins; last_grant updates on every grant.
  - wait_cnt and MAX_WAIT are removed from the logic.
- Undefined: fixed priority with starvation guard, as described under Behaviour.

Test Plan:
- Port 0 alone: write 0x0000_00AB to addr 0x010, then read 0x010 → gnt0 same cycle each; rvalid0 = 1 exactly READ_LATENCY cycles after the read grant; rdata0 = 0x0000_00AB; rvalid1 never high.
- Contention, MAX_WAIT = 4: req0 and req1 held high continuously → gnt0 for 4 cycles, gnt1 on the 5th, pattern repeats; mem_wren only in write-grant cycles.
- Alternating reads with READ_LATENCY = 2: port 0 reads 0x020 (holds 0x11), then port 1 reads 0x021 (holds 0x22) → rvalid0 with 0x11, then rvalid1 with 0x22 next cycle; in order, no cross-delivery.
- Reset asserted asynchronously one cycle after a port 1 read grant → rvalid1 stays 0 after deassert; wait_cnt = 0; first post-reset req0 is granted immediately.
- Idle: no req for 10 cycles → mem_wren = 0, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0 throughout.
- With DMEM_ARB_RR_EN, both ports requesting continuously → grants alternate 0,1,0,1 starting with port 0 after reset.
